secp256k1_sub_arbiter: RTL and testbench
========================================

# secp256k1_sub_arbiter

Shares one `secp256k1_sub_mod` instance (3-cycle start/done modular subtractor, r = (a − b) mod p) among `N_REQ` requesters in the point-arithmetic layer. Uses per-requester valid/ready request channels, round-robin arbitration and one shared response channel tagged with the requester index. Exactly one operation is in flight at a time.

## Interface
- `N_REQ`, default 4: number of requesters, 1..16.
- `ID_W`, default `$clog2(N_REQ)` with a minimum of 1: requester-index width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset. Also drives the embedded `secp256k1_sub_mod`.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; one-hot or zero.
- `req_a`  in  `256*N_REQ`  operand a. Slice i is `[256*i +: 256]`.
- `req_b`  in  `256*N_REQ`  operand b, same packing.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_data`  out  256  (a − b) mod p.
- `resp_id`  out  `ID_W`  index of the requester that owns `resp_data`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when a request is accepted.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP on the unit's `done`.
  - RESP → IDLE when `resp_ready` is high.
- IDLE, grant selection:
  - Grant g is the first i with `req_valid[i]`=1, searching from `rr_ptr` upward with wrap modulo `N_REQ`.
  - `req_ready` = onehot(g), combinational. It is zero in all other states, when no request is valid, and while `rst_n` is low.
- IDLE, accept: on `req_valid[g] && req_ready[g]`, register operand slice g into `op_a`/`op_b` and g into `gnt_id`, then go to ISSUE.
- ISSUE:
  - Drive unit `start`=1 for exactly this cycle, with `a`=`op_a` and `b`=`op_b`.
  - Unit `start` is 0 in every other state.
- WAIT:
  - Hold until the unit's `done`=1.
  - On that edge, capture the unit `result` into `resp_data` and go to RESP.
  - Unit `done` seen in any other state is ignored.
- RESP:
  - `resp_valid`=1; `resp_data` and `resp_id`=`gnt_id` are held stable.
  - On `resp_ready`=1: clear `resp_valid`, set `rr_ptr` = (`gnt_id`+1) mod `N_REQ`, go to IDLE.
  - No new request is accepted in the cycle of the response handshake.
- Requester obligations: requesters keep `req_valid` and operands stable until accepted. The block does not check this.
- Operand range:
  - Inputs are required to be < p.
  - Out-of-range operands return the unit's raw single-correction result; no flagging.
- Reset mid-operation: all state returns to IDLE and `rr_ptr`=0. The in-flight operation is discarded and no response is produced.
- `N_REQ`=1 degenerates to a pass-through sequencer; `rr_ptr` stays 0.

## Timing
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `busy`=0.
  - `rr_ptr`=0; state IDLE.
  - Stats counters = 0.
- Request handshake in cycle T:
  - `start` asserted in T+1.
  - Unit `done` high in T+4.
  - `resp_valid` high from T+5.
- Throughput: with `resp_ready` tied high, RESP lasts 1 cycle and the next accept is in T+6, i.e. one operation per 6 cycles.
- Backpressure: `resp_valid` stays high and `resp_data`/`resp_id` stay unchanged while `resp_ready`=0. `req_ready` stays 0 throughout.
- `busy` is registered from the state and goes high in T+1.

## Configuration
- Macro `SECP256K1_SUB_ARB_STATS_EN`.
- Defined: adds two outputs.
  - `stat_ops` (32): increments on each response handshake.
  - `stat_stall` (32): increments every cycle in which `|req_valid` is high and no request is accepted.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `secp256k1_pkg`:
  - Constant `SECP256K1_P`.
  - Width constant `FE_W`=256.
  - FSM state enum type `sub_arb_state_t`.
- Sub-module `secp256k1_rr_picker`: combinational round-robin picker, inputs `req`, `ptr`; outputs `gnt_onehot`, `gnt_idx`, `any`.
- Datapath: one `secp256k1_sub_mod` instance.

## Test plan
- Single op, a=5, b=3 from requester 2 → `resp_data`=2, `resp_id`=2; `resp_valid` rises 5 cycles after the handshake.
- Borrow case, a=3, b=5 from requester 0 → `resp_data`=0xFFFF…FFFEFFFFFC2D (p−2).
- All 4 requesters valid continuously from reset → grant order 0,1,2,3,0. With only requesters 0 and 2 valid after serving 3 → 0 then 2.
- `resp_ready` held low for 10 cycles in RESP while requester 1 is valid:
  - `resp_valid`, `resp_data` and `resp_id` are stable.
  - `req_ready`=0 and `busy`=1.
  - Requester 1 is accepted the cycle after the response handshake.
- Reset pulsed during WAIT → all outputs return to reset values, no `resp_valid` for that op, and the next request is granted from index 0.
- With `SECP256K1_SUB_ARB_STATS_EN`, three back-to-back ops from requesters 0 and 1 → `stat_ops`=3, and `stat_stall` equals the count of cycles with pending unaccepted requests.

Source files
------------

// File: rtl/secp256k1_pkg.sv
// secp256k1 shared package: field constants and arbiter FSM state type.
// Contents: FE_W, SECP256K1_P, sub_arb_state_t.
package secp256k1_pkg;

    // Field element width in bits.
    localparam int FE_W = 256;

    // Field prime p = 2^256 - 2^32 - 977.
    localparam logic [FE_W-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } sub_arb_state_t;

endpackage

// File: rtl/secp256k1_sub_arbiter_if.sv
// Request/response bundle between requesters and the shared subtractor.
// master: requester/consumer side; slave: arbiter side.
interface secp256k1_sub_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    import secp256k1_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [FE_W*N_REQ-1:0] req_a;
    logic [FE_W*N_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [FE_W-1:0]       resp_data;
    logic [ID_W-1:0]       resp_id;
    logic                  busy;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_id,
        output busy
    );

endinterface

// File: rtl/secp256k1_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// Ports: req, ptr in; gnt_onehot, gnt_idx, any out.
module secp256k1_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    logic found;

    // Two passes replace a modulo walk: indices >= ptr first, then the
    // wrapped remainder; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (ID_W'(i) >= ptr)) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = ID_W'(i);
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/secp256k1_sub_mod.sv
// Modular subtractor r = (a - b) mod p with one conditional +p correction.
// Ports: start_i, a_i, b_i in; done_o (3 cycles after start_i), result_o out.
module secp256k1_sub_mod
    import secp256k1_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [FE_W-1:0] a_i,
    input  logic [FE_W-1:0] b_i,
    output logic            done_o,
    output logic [FE_W-1:0] result_o
);

    logic [FE_W:0]   sub_w;
    logic [FE_W-1:0] diff_q;
    logic            borrow_q;
    logic            v1_q;
    logic [FE_W-1:0] corr_q;
    logic            v2_q;
    logic [FE_W-1:0] result_q;
    logic            v3_q;

    assign sub_w = {1'b0, a_i} - {1'b0, b_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
            v1_q     <= 1'b0;
            corr_q   <= '0;
            v2_q     <= 1'b0;
            result_q <= '0;
            v3_q     <= 1'b0;
        end else begin
            v1_q <= start_i;
            if (start_i) begin
                diff_q   <= sub_w[FE_W-1:0];
                borrow_q <= sub_w[FE_W];
            end
            // A borrow means the raw difference wrapped mod 2^256;
            // adding p (mod 2^256) lands it back in the field.
            v2_q <= v1_q;
            if (v1_q) begin
                corr_q <= borrow_q ? (diff_q + SECP256K1_P) : diff_q;
            end
            v3_q <= v2_q;
            if (v2_q) begin
                result_q <= corr_q;
            end
        end
    end

    assign done_o   = v3_q;
    assign result_o = result_q;

endmodule

// File: rtl/secp256k1_sub_arbiter.sv
// Round-robin sharing of one secp256k1_sub_mod among N_REQ requesters.
// Ports: clk, rst_n, bus (slave modport); stat_ops/stat_stall with SECP256K1_SUB_ARB_STATS_EN.
module secp256k1_sub_arbiter
    import secp256k1_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    secp256k1_sub_arbiter_if.slave  bus
`ifdef SECP256K1_SUB_ARB_STATS_EN
    ,
    output logic [31:0]             stat_ops,
    output logic [31:0]             stat_stall
`endif
);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_ISSUE = ARB_ISSUE;
    localparam logic [1:0] S_WAIT  = ARB_WAIT;
    localparam logic [1:0] S_RESP  = ARB_RESP;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [FE_W-1:0] op_a_q, op_a_d;
    logic [FE_W-1:0] op_b_q, op_b_d;
    logic [FE_W-1:0] resp_data_q, resp_data_d;
    logic            busy_q;

    logic [N_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             idle;
    logic             accept;
    logic             resp_hs;
    logic [FE_W-1:0]  sel_a;
    logic [FE_W-1:0]  sel_b;

    logic             unit_start;
    logic             unit_done;
    logic [FE_W-1:0]  unit_result;

    secp256k1_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req        (bus.req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign idle          = (state_q == S_IDLE);
    assign bus.req_ready = (rst_n && idle) ? gnt_onehot : '0;
    assign accept        = rst_n && idle && gnt_any;
    assign resp_hs       = (state_q == S_RESP) && bus.resp_ready;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                sel_a = bus.req_a[FE_W*i +: FE_W];
                sel_b = bus.req_b[FE_W*i +: FE_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_ISSUE;
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    gnt_id_d = gnt_idx;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (unit_done) begin
                    state_d     = S_RESP;
                    resp_data_d = unit_result;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    if (gnt_id_q == ID_W'(N_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_id_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            resp_data_q <= resp_data_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign unit_start = (state_q == S_ISSUE);

    secp256k1_sub_mod u_sub (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (unit_start),
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .done_o   (unit_done),
        .result_o (unit_result)
    );

    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = gnt_id_q;
    assign bus.busy       = busy_q;

`ifdef SECP256K1_SUB_ARB_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (resp_hs) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end
            if ((|bus.req_valid) && !accept) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_ops   = stat_ops_q;
    assign stat_stall = stat_stall_q;
`else
    logic unused_hs;
    assign unused_hs = resp_hs;
`endif

endmodule

// File: tb/tb_secp256k1_sub_arbiter.sv
// Directed bench for secp256k1_sub_arbiter (N_REQ=4).
// Immediate assertions at each check point; one summary line at the end.
module tb_secp256k1_sub_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [255:0] PM2 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    secp256k1_sub_arbiter_if #(.N_REQ(4)) bus ();

`ifdef SECP256K1_SUB_ARB_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    secp256k1_sub_arbiter #(.N_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SECP256K1_SUB_ARB_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Present a request at this negedge, check the grant, then drop it
    // one cycle later (after the accepting edge).
    task automatic issue(input int id, input logic [255:0] a,
                         input logic [255:0] b, input logic [3:0] exp_rdy,
                         input string tag);
        bus.req_a[256*id +: 256] = a;
        bus.req_b[256*id +: 256] = b;
        bus.req_valid = bus.req_valid | (4'b0001 << id);
        #1;
        chk(tag, bus.req_ready, exp_rdy);
        @(negedge clk);
        bus.req_valid = bus.req_valid & ~(4'b0001 << id);
    endtask

    // Called in the cycle after the handshake; returns cycles since handshake.
    task automatic wait_resp(output int n);
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int g[$];
    int t[$];
    int cyc;
    bit sw;
    bit bad;
    int exp_g[6];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b0;
        exp_g = '{0, 1, 2, 3, 0, 2};

        // Reset values, including req_ready masked while in reset.
        repeat (2) @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_busy", bus.busy, 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op: 5 - 3 from requester 2.
        issue(2, 256'd5, 256'd3, 4'b0100, "t1_ready");
        chk("t1_busy", bus.busy, 1);
        wait_resp(n);
        chk("t1_latency", n, 5);
        chk("t1_data", bus.resp_data, 2);
        chk("t1_id", bus.resp_id, 2);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("t1_valid_drop", bus.resp_valid, 0);
        chk("t1_busy_drop", bus.busy, 0);

        // Borrow: 3 - 5 from requester 0 (ptr=3, wraps to 0).
        issue(0, 256'd3, 256'd5, 4'b0001, "t2_ready");
        wait_resp(n);
        chk("t2_latency", n, 5);
        chk("t2_data", bus.resp_data, PM2);
        chk("t2_id", bus.resp_id, 0);
        bus.resp_ready = 1'b1;
        @(negedge clk);

        // Round robin from reset, all valid, resp_ready tied high.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[256*i +: 256] = 256'(i + 10);
            bus.req_b[256*i +: 256] = 256'(i);
        end
        bus.req_valid = 4'b1111;
        cyc = 0;
        sw = 1'b0;
        #1;
        while (g.size() < 6 && cyc < 100) begin
            if (|bus.req_ready) begin
                g.push_back(oh2idx(bus.req_ready));
                t.push_back(cyc);
            end
            if (g.size() == 4 && !sw && t[3] != cyc) begin
                bus.req_valid = 4'b0101;
                sw = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rr_count", g.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_grant%0d", i), (i < g.size()) ? g[i] : -1,
                exp_g[i]);
        end
        chk("rr_spacing", (t.size() > 1) ? t[1] - t[0] : 0, 6);
        bus.req_valid = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rr_drained", bus.busy, 0);
        bus.resp_ready = 1'b0;

        // Backpressure: op from 3 (ptr=3), requester 1 waits meanwhile.
        issue(3, 256'd20, 256'd4, 4'b1000, "bp_ready");
        bus.req_a[256*1 +: 256] = 256'd100;
        bus.req_b[256*1 +: 256] = 256'd1;
        bus.req_valid = 4'b0010;
        wait_resp(n);
        chk("bp_latency", n, 5);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 256'd16 ||
                bus.resp_id !== 2'd3 || bus.req_ready !== 4'b0000 ||
                bus.busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        chk("bp_stable", bad, 0);
        chk("bp_data", bus.resp_data, 16);
        chk("bp_id", bus.resp_id, 3);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("bp_next_ready", bus.req_ready, 4'b0010);
        chk("bp_valid_drop", bus.resp_valid, 0);
        @(negedge clk);
        bus.req_valid = '0;
        wait_resp(n);
        chk("bp2_latency", n, 5);
        chk("bp2_data", bus.resp_data, 99);
        chk("bp2_id", bus.resp_id, 1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Reset during WAIT: op from 3 (ptr=2), discarded.
        issue(3, 256'd50, 256'd1, 4'b1000, "rw_ready");
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("rw_req_ready", bus.req_ready, 0);
        chk("rw_resp_valid", bus.resp_valid, 0);
        chk("rw_resp_data", bus.resp_data, 0);
        chk("rw_resp_id", bus.resp_id, 0);
        chk("rw_busy", bus.busy, 0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("rw_no_resp", bad, 0);
        bus.req_valid = 4'b1111;
        #1;
        chk("rw_ptr0", bus.req_ready, 4'b0001);
        bus.req_valid = '0;

`ifdef SECP256K1_SUB_ARB_STATS_EN
        // Three back-to-back ops from 0 and 1: accepts at T0, T0+6, T0+12,
        // last handshake at T0+17; 5 stalled cycles per op.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        bus.req_valid = 4'b0011;
        repeat (18) @(negedge clk);
        bus.req_valid = '0;
        chk("st_ops", stat_ops, 3);
        chk("st_stall", stat_stall, 15);
        bus.resp_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
